// File: rtl/key_evt_pkg.sv
// Shared definitions for the key/switch local-bus controller:
// bus slave view, register map, EVENT field layout and idle levels.
package key_evt_pkg;

    typedef struct packed {
        logic [1:0]  addr;
        logic        wr;
        logic [15:0] wdata;
    } lb_slave_t;

    localparam logic [1:0] REG_KEY_STATE = 2'd0;
    localparam logic [1:0] REG_EVENT     = 2'd1;
    localparam logic [1:0] REG_IRQ_EN    = 2'd2;
    localparam logic [1:0] REG_SW_STATE  = 2'd3;

    localparam int EVT_PRESS_LSB   = 0;
    localparam int EVT_RELEASE_LSB = 8;

    // Raw pin levels meaning "inactive": keys idle high, switches idle low
    localparam logic KEY_IDLE_LVL = 1'b1;
    localparam logic SW_IDLE_LVL  = 1'b0;

endpackage

// File: rtl/debounce_cell.sv
// One input bit: 2-FF synchroniser, tick-based stability counter,
// debounced active-high level plus single-cycle rise/fall strobes.
module debounce_cell #(
    parameter int   STABLE_TICKS = 20,
    parameter logic RST_VAL      = 1'b0
) (
    input  logic lb_clk,
    input  logic rst,
    input  logic tick,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(STABLE_TICKS + 1);

    logic          s1_q, s2_q;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sample;

    // XOR with the idle level turns the raw pin into "active" polarity
    assign sample = s2_q ^ RST_VAL;

    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (tick) begin
            if (sample == db_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(STABLE_TICKS - 1)) begin
                db_d  = ~db_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge lb_clk) begin
        if (rst) begin
            s1_q  <= RST_VAL;
            s2_q  <= RST_VAL;
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= din;
            s2_q  <= s1_q;
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout = db_q;
    assign rise = db_d & ~db_q;
    assign fall = ~db_d & db_q;

endmodule

// File: rtl/key_event_ctrl_lbus.sv
// Key/switch controller: debounce bank, sticky press/release events,
// masked level interrupt and a 4-register local-bus view.
module key_event_ctrl_lbus
    import key_evt_pkg::*;
#(
    parameter int KEY_NUM      = 4,
    parameter int SW_NUM       = 3,
    parameter int TICK_DIV     = 12000,
    parameter int STABLE_TICKS = 20
) (
    input  logic                lb_clk,
    input  logic                rst,
    input  lb_slave_t           xt_lb,
    output logic [15:0]         rdata,
    input  logic [KEY_NUM-1:0]  key_raw,
    input  logic [SW_NUM-1:0]   sw_raw,
    output logic                irq
);

    localparam int DW = $clog2(TICK_DIV);

    logic [DW-1:0]      div_q, div_d;
    logic               tick;
    logic [KEY_NUM-1:0] key_db, key_rise, key_fall;
    logic [SW_NUM-1:0]  sw_db, sw_rise_unused, sw_fall_unused;
    logic [KEY_NUM-1:0] press_q, press_d, rel_q, rel_d;
    logic [KEY_NUM-1:0] en_press_q, en_press_d, en_rel_q, en_rel_d;
    logic               irq_q, irq_d;
    logic               ev_wr, en_wr;
    logic [KEY_NUM-1:0] press_clr, rel_clr;
    logic               wdata_unused;

    assign wdata_unused = ^xt_lb.wdata;
    assign tick         = (div_q == DW'(TICK_DIV - 1));
    assign div_d        = tick ? '0 : div_q + 1'b1;

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
        debounce_cell #(
            .STABLE_TICKS (STABLE_TICKS),
            .RST_VAL      (KEY_IDLE_LVL)
        ) u_cell (
            .lb_clk (lb_clk),
            .rst    (rst),
            .tick   (tick),
            .din    (key_raw[i]),
            .dout   (key_db[i]),
            .rise   (key_rise[i]),
            .fall   (key_fall[i])
        );
    end

    for (genvar i = 0; i < SW_NUM; i++) begin : g_sw
        debounce_cell #(
            .STABLE_TICKS (STABLE_TICKS),
            .RST_VAL      (SW_IDLE_LVL)
        ) u_cell (
            .lb_clk (lb_clk),
            .rst    (rst),
            .tick   (tick),
            .din    (sw_raw[i]),
            .dout   (sw_db[i]),
            .rise   (sw_rise_unused[i]),
            .fall   (sw_fall_unused[i])
        );
    end

    always_comb begin
        ev_wr     = xt_lb.wr && (xt_lb.addr == REG_EVENT);
        en_wr     = xt_lb.wr && (xt_lb.addr == REG_IRQ_EN);
        press_clr = ev_wr ? xt_lb.wdata[EVT_PRESS_LSB +: KEY_NUM] : '0;
        rel_clr   = ev_wr ? xt_lb.wdata[EVT_RELEASE_LSB +: KEY_NUM] : '0;
        // New edges are OR-ed in after the clear so a same-cycle set wins
        press_d   = (press_q & ~press_clr) | key_rise;
        rel_d     = (rel_q & ~rel_clr) | key_fall;
        en_press_d = en_wr ? xt_lb.wdata[EVT_PRESS_LSB +: KEY_NUM] : en_press_q;
        en_rel_d   = en_wr ? xt_lb.wdata[EVT_RELEASE_LSB +: KEY_NUM] : en_rel_q;
        irq_d     = |(press_q & en_press_q) | |(rel_q & en_rel_q);
    end

    always_ff @(posedge lb_clk) begin
        if (rst) begin
            div_q      <= '0;
            press_q    <= '0;
            rel_q      <= '0;
            en_press_q <= '0;
            en_rel_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            div_q      <= div_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
            en_press_q <= en_press_d;
            en_rel_q   <= en_rel_d;
            irq_q      <= irq_d;
        end
    end

    assign irq = irq_q;

    always_comb begin
        rdata = '0;
        case (xt_lb.addr)
            REG_KEY_STATE: rdata[KEY_NUM-1:0] = key_db;
            REG_EVENT: begin
                rdata[EVT_PRESS_LSB +: KEY_NUM]   = press_q;
                rdata[EVT_RELEASE_LSB +: KEY_NUM] = rel_q;
            end
            REG_IRQ_EN: begin
                rdata[EVT_PRESS_LSB +: KEY_NUM]   = en_press_q;
                rdata[EVT_RELEASE_LSB +: KEY_NUM] = en_rel_q;
            end
            default: rdata[SW_NUM-1:0] = sw_db;
        endcase
    end

endmodule
